// File: rtl/conv_tile_sched.sv
// conv_tile_sched: walks the (row, col, n, m) tile loop nest of one conv layer, issuing
// one-cycle loader/compute/store start pulses and waiting on each matching done pulse.
module conv_tile_sched #(
  parameter int CW = 16,
  parameter int R  = 64,
  parameter int C  = 32,
  parameter int M  = 48,
  parameter int N  = 32,
  parameter int Tr = 64,
  parameter int Tc = 16,
  parameter int Tm = 16,
  parameter int Tn = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          conv_start,
  output logic          conv_done,
  output logic          busy,
  output logic          ld_init_data_start,
  input  logic          ld_init_data_done,
  output logic          in_fm_load_start,
  input  logic          in_fm_load_done,
  output logic          weight_load_start,
  input  logic          weight_load_done,
  output logic          conv_computing_start,
  input  logic          conv_computing_done,
  output logic          st_result_data_start,
  input  logic          st_result_data_done,
  output logic [CW-1:0] tile_row,
  output logic [CW-1:0] tile_col,
  output logic [CW-1:0] tile_n,
  output logic [CW-1:0] tile_m
);
  localparam int NR = R / Tr;
  localparam int NC = C / Tc;
  localparam int NM = M / Tm;
  localparam int NN = N / Tn;
  localparam logic [CW-1:0] R_LAST = CW'(NR - 1);
  localparam logic [CW-1:0] C_LAST = CW'(NC - 1);
  localparam logic [CW-1:0] M_LAST = CW'(NM - 1);
  localparam logic [CW-1:0] N_LAST = CW'(NN - 1);
  if (R % Tr != 0 || C % Tc != 0 || M % Tm != 0 || N % Tn != 0 ||
      NR < 1 || NC < 1 || NM < 1 || NN < 1) begin : g_bad_cfg
    $error("conv_tile_sched: every tile size must divide its layer dimension with at least one tile");
  end
  typedef enum logic [2:0] {IDLE, LD_INIT, LD_TILE, COMP, STORE, FIN} state_t;
  state_t state, state_nxt;
  logic in_ok, w_ok, in_hit, w_hit, init_hit, comp_hit, st_hit, enter;
  logic n_last, col_last, row_last;
  logic [CW-1:0] row_nxt, col_nxt, n_nxt, m_nxt;
  // a done landing in its own start cycle is treated as stray
  always_comb begin
    in_hit = state == LD_TILE && in_fm_load_done && !in_fm_load_start;
    w_hit = state == LD_TILE && weight_load_done && !weight_load_start;
    init_hit = state == LD_INIT && ld_init_data_done && !ld_init_data_start;
    comp_hit = state == COMP && conv_computing_done && !conv_computing_start;
    st_hit = state == STORE && st_result_data_done && !st_result_data_start;
    n_last = tile_n == N_LAST;
    col_last = tile_col == C_LAST;
    row_last = tile_row == R_LAST;
    state_nxt = state;
    row_nxt = tile_row;
    col_nxt = tile_col;
    n_nxt = tile_n;
    m_nxt = tile_m;
    case (state)
      IDLE: if (conv_start) begin
        state_nxt = LD_INIT;
        {row_nxt, col_nxt, n_nxt, m_nxt} = '0;
      end
      LD_INIT: if (init_hit) state_nxt = LD_TILE;
      LD_TILE: if ((in_ok || in_hit) && (w_ok || w_hit)) state_nxt = COMP;
      COMP: if (comp_hit) begin
        state_nxt = tile_m != M_LAST ? LD_TILE : STORE;
        m_nxt = tile_m != M_LAST ? tile_m + 1'b1 : tile_m;
      end
      STORE: if (st_hit) begin
        m_nxt = '0;
        n_nxt = n_last ? '0 : tile_n + 1'b1;
        col_nxt = !n_last ? tile_col : col_last ? '0 : tile_col + 1'b1;
        row_nxt = !(n_last && col_last) ? tile_row : row_last ? '0 : tile_row + 1'b1;
        state_nxt = n_last && col_last && row_last ? FIN : LD_INIT;
      end
      FIN: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    enter = state_nxt != state;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      {in_ok, w_ok, busy, conv_done} <= '0;
      {ld_init_data_start, in_fm_load_start, weight_load_start} <= '0;
      {conv_computing_start, st_result_data_start} <= '0;
      {tile_row, tile_col, tile_n, tile_m} <= '0;
    end else begin
      state <= state_nxt;
      tile_row <= row_nxt;
      tile_col <= col_nxt;
      tile_n <= n_nxt;
      tile_m <= m_nxt;
      in_ok <= state_nxt == LD_TILE && (in_ok || in_hit);
      w_ok <= state_nxt == LD_TILE && (w_ok || w_hit);
      busy <= state_nxt != IDLE;
      ld_init_data_start <= enter && state_nxt == LD_INIT;
      in_fm_load_start <= enter && state_nxt == LD_TILE;
      weight_load_start <= enter && state_nxt == LD_TILE;
      conv_computing_start <= enter && state_nxt == COMP;
      st_result_data_start <= enter && state_nxt == STORE;
      conv_done <= enter && state_nxt == FIN;
    end
  end
endmodule

// File: tb/tb_conv_tile_sched.sv
// tb_conv_tile_sched: two sequencer instances (NR=NC=1 and NR=NC=2; NN=2, NM=3) driven by
// auto/manual done responders; a loop-nest model fills the expected start-pulse queue.
module tb_conv_tile_sched;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  logic cs[2], cdone[2], busy[2];
  logic [4:0] st[2], dn[2], auto_dn[2], man_dn[2];
  logic [15:0] trow[2], tcol[2], tn[2], tm[2];
  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic s0, s1, s2, s3, s4;
    assign st[g] = {s4, s3, s2, s1, s0};
    assign dn[g] = auto_dn[g] | man_dn[g];
    conv_tile_sched #(.R(g ? 128 : 64), .C(g ? 32 : 16)) dut (
      .clk(clk), .rst(rst), .conv_start(cs[g]), .conv_done(cdone[g]), .busy(busy[g]),
      .ld_init_data_start(s0), .ld_init_data_done(dn[g][0]),
      .in_fm_load_start(s1), .in_fm_load_done(dn[g][1]),
      .weight_load_start(s2), .weight_load_done(dn[g][2]),
      .conv_computing_start(s3), .conv_computing_done(dn[g][3]),
      .st_result_data_start(s4), .st_result_data_done(dn[g][4]),
      .tile_row(trow[g]), .tile_col(tcol[g]), .tile_n(tn[g]), .tile_m(tm[g])
    );
  end
  typedef struct {int g; int ev; int row; int col; int n; int m;} ev_t;
  typedef struct {int g; int li; int lw; int lo; int e_init; int e_ld; int e_st;} vec_t;
  ev_t sbq[$];
  vec_t tbl[5];
  int checks = 0, failures = 0;
  int lat[2][5];
  int pc[2][5];
  int dcount[2];
  int base[5];
  int bd;
  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask
  function automatic void push(int g, int ev, int r, int c, int n, int m);
    sbq.push_back('{g, ev, r, c, n, m});
  endfunction
  // reference loop nest: events 0=init 1=load(in+w) 2=comp 3=store 4=conv_done
  function automatic void push_layer(int g);
    for (int r = 0; r < (g ? 2 : 1); r++)
      for (int c = 0; c < (g ? 2 : 1); c++)
        for (int n = 0; n < 2; n++) begin
          push(g, 0, r, c, n, 0);
          for (int m = 0; m < 3; m++) begin
            push(g, 1, r, c, n, m);
            push(g, 2, r, c, n, m);
          end
          push(g, 3, r, c, n, 2);
        end
    push(g, 4, -1, -1, -1, -1);
  endfunction
  task automatic monitor();
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        int ev;
        ev_t e;
        ev = cdone[g] ? (st[g] == 0 ? 4 : 9) :
             st[g] == 5'b00001 ? 0 : st[g] == 5'b00110 ? 1 : st[g] == 5'b01000 ? 2 :
             st[g] == 5'b10000 ? 3 : st[g] == 0 ? -1 : 9;
        for (int k = 0; k < 5; k++) if (st[g][k]) pc[g][k]++;
        if (cdone[g]) dcount[g]++;
        if (ev >= 0) begin
          checks++;
          if (sbq.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected: dut%0d event %0d, required no event", g, ev);
          end else begin
            e = sbq.pop_front();
            if (e.g != g || e.ev != ev || (e.row >= 0 && (int'(trow[g]) != e.row ||
                int'(tcol[g]) != e.col || int'(tn[g]) != e.n || int'(tm[g]) != e.m))) begin
              failures++;
              $display("FAIL sb_event: got dut%0d ev=%0d (r%0d c%0d n%0d m%0d), required dut%0d ev=%0d (r%0d c%0d n%0d m%0d)",
                g, ev, trow[g], tcol[g], tn[g], tm[g], e.g, e.ev, e.row, e.col, e.n, e.m);
            end
          end
        end
      end
    end
  endtask
  task automatic responder();
    int c[2][5];
    for (int g = 0; g < 2; g++) for (int k = 0; k < 5; k++) c[g][k] = 0;
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++)
        for (int k = 0; k < 5; k++) begin
          auto_dn[g][k] = 1'b0;
          if (c[g][k] > 0) begin
            c[g][k]--;
            if (c[g][k] == 0) auto_dn[g][k] = 1'b1;
          end
          if (st[g][k] && lat[g][k] > 0) c[g][k] = lat[g][k];
        end
    end
  endtask
  task automatic set_lat(int g, int li, int lw, int lo);
    lat[g][0] = lo; lat[g][1] = li; lat[g][2] = lw; lat[g][3] = lo; lat[g][4] = lo;
  endtask
  task automatic begin_layer(int g);
    for (int k = 0; k < 5; k++) base[k] = pc[g][k];
    bd = dcount[g];
    push_layer(g);
    @(negedge clk) cs[g] = 1;
    @(negedge clk) cs[g] = 0;
  endtask
  task automatic wait_st(int g, int k, string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (!st[g][k] && n < 500);
    check($sformatf("%s_seen", name), int'(st[g][k]), 1);
  endtask
  task automatic finish_layer(int g, int ei, int el, int es, string tag);
    int n = 0;
    while (dcount[g] == bd && n < 3000) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    check($sformatf("%s_init_cnt", tag), pc[g][0] - base[0], ei);
    check($sformatf("%s_in_cnt", tag), pc[g][1] - base[1], el);
    check($sformatf("%s_w_cnt", tag), pc[g][2] - base[2], el);
    check($sformatf("%s_comp_cnt", tag), pc[g][3] - base[3], el);
    check($sformatf("%s_store_cnt", tag), pc[g][4] - base[4], es);
    check($sformatf("%s_done_cnt", tag), dcount[g] - bd, 1);
    check($sformatf("%s_busy_after", tag), int'(busy[g]), 0);
    check($sformatf("%s_sb_left", tag), sbq.size(), 0);
    sbq.delete();
  endtask
  task automatic check_zero(int g, string tag);
    check($sformatf("%s_busy", tag), int'(busy[g]), 0);
    check($sformatf("%s_done", tag), int'(cdone[g]), 0);
    check($sformatf("%s_starts", tag), int'(st[g]), 0);
    check($sformatf("%s_idx", tag), int'(trow[g] | tcol[g] | tn[g] | tm[g]), 0);
  endtask
  initial begin
    int early, d0;
    tbl[0] = '{0, 3, 3, 3, 2, 6, 2};
    tbl[1] = '{0, 2, 9, 3, 2, 6, 2};
    tbl[2] = '{0, 1, 1, 1, 2, 6, 2};
    tbl[3] = '{1, 3, 3, 3, 8, 24, 8};
    tbl[4] = '{1, 4, 1, 2, 8, 24, 8};
    for (int g = 0; g < 2; g++) begin
      cs[g] = 0; man_dn[g] = '0; auto_dn[g] = '0; dcount[g] = 0;
      for (int k = 0; k < 5; k++) pc[g][k] = 0;
      set_lat(g, 3, 3, 3);
    end
    fork
      monitor();
      responder();
    join_none
    #1 rst = 0;
    #1 check_zero(0, "reset0");
    check_zero(1, "reset1");
    repeat (2) @(negedge clk);
    rst = 1;
    // stray dones while idle must not start anything
    @(negedge clk) man_dn[0] = 5'h1f;
    @(negedge clk) man_dn[0] = '0;
    repeat (2) @(negedge clk);
    check("idle_stray_busy", int'(busy[0]), 0);
    check("idle_stray_starts", pc[0][0] + pc[0][1] + pc[0][4], 0);
    for (int i = 0; i < 5; i++) begin
      set_lat(tbl[i].g, tbl[i].li, tbl[i].lw, tbl[i].lo);
      begin_layer(tbl[i].g);
      finish_layer(tbl[i].g, tbl[i].e_init, tbl[i].e_ld, tbl[i].e_st, $sformatf("vec%0d", i));
    end
    // done ordering inside a tile load, driven by hand
    set_lat(0, 0, 0, 3);
    begin_layer(0);
    wait_st(0, 1, "ord_load0");
    early = 0;
    for (int j = 1; j <= 9; j++) begin
      @(negedge clk);
      early |= int'(st[0][3]);
      man_dn[0][1] = j == 2;
      man_dn[0][2] = j == 9;
    end
    @(negedge clk) man_dn[0] = '0;
    check("ord_split_no_early_comp", early, 0);
    check("ord_split_comp_next", int'(st[0][3]), 1);
    @(negedge clk) check("ord_split_comp_once", int'(st[0][3]), 0);
    wait_st(0, 1, "ord_load1");
    man_dn[0][2:1] = 2'b11;
    @(negedge clk) man_dn[0] = '0;
    early = int'(st[0][3]);
    @(negedge clk) man_dn[0][2:1] = 2'b11;
    early |= int'(st[0][3]);
    @(negedge clk) man_dn[0] = '0;
    check("ord_startcycle_done_ignored", early, 0);
    check("ord_same_comp_next", int'(st[0][3]), 1);
    @(negedge clk) check("ord_same_comp_once", int'(st[0][3]), 0);
    set_lat(0, 3, 3, 3);
    finish_layer(0, 2, 6, 2, "ord");
    // conv_start re-pulse and stray store done during COMP
    begin_layer(0);
    wait_st(0, 3, "stray_comp");
    @(negedge clk);
    cs[0] = 1;
    man_dn[0][4] = 1;
    check("stray_busy", int'(busy[0]), 1);
    @(negedge clk);
    cs[0] = 0;
    man_dn[0] = '0;
    finish_layer(0, 2, 6, 2, "stray");
    // async reset in COMP of tile_m=1, then a clean layer
    d0 = dcount[0];
    begin_layer(0);
    wait_st(0, 3, "abort_comp0");
    wait_st(0, 3, "abort_comp1");
    check("abort_tile_m", int'(tm[0]), 1);
    @(posedge clk);
    #2 rst = 0;
    #1 check_zero(0, "abort_async");
    sbq.delete();
    repeat (3) @(negedge clk);
    rst = 1;
    repeat (8) @(negedge clk);
    check("abort_no_conv_done", dcount[0] - d0, 0);
    check_zero(0, "abort_idle");
    begin_layer(0);
    finish_layer(0, 2, 6, 2, "after_abort");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
